// File: rtl/tc_cbuffer.sv
// Tile-accumulating result buffer: collects TILE_M x TILE_N result tiles of an
// M x N matrix (overwrite or per-element accumulate) and streams the matrix out
// row by row over a valid/ready interface, clearing itself when the drain ends.
module tc_cbuffer #(
  parameter int unsigned M       = 16,
  parameter int unsigned N       = 16,
  parameter int unsigned TILE_M  = 4,
  parameter int unsigned TILE_N  = 4,
  parameter int unsigned iterM   = M / TILE_M,
  parameter int unsigned iterN   = N / TILE_N,
  parameter int unsigned N_iter  = iterM * iterN,
  parameter int unsigned DW_MEM  = 512,
  parameter int unsigned DW_IDX  = 4,
  parameter int unsigned DW_DATA = 32,
  parameter int unsigned DW_TILE = TILE_M * TILE_N * DW_DATA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tile_we,
  input  logic                tile_acc,
  input  logic [DW_IDX-1:0]   tile_ptr,
  input  logic [DW_TILE-1:0]  C_tile,
  input  logic                drain_start,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW_MEM-1:0]   out_data,
  output logic [DW_IDX-1:0]   out_row,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned ROW_W  = TILE_N * DW_DATA;
  localparam int unsigned N_ELEM = TILE_M * TILE_N;
  localparam int unsigned IDX_W  = (N_iter > 1) ? $clog2(N_iter) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [DW_TILE-1:0]  tiles [N_iter];
  logic [DW_IDX-1:0]   row;
  logic [DW_TILE-1:0]  cur_tile;
  logic [DW_TILE-1:0]  wr_tile;
  logic                ptr_ok;
  int unsigned         rd_base;
  int unsigned         rd_sub;

  assign out_row = row;

  // Next tile value: overwrite, or lane-wise wrap-around add with no cross-lane carry
  always_comb begin
    ptr_ok   = 32'(tile_ptr) < N_iter;
    cur_tile = tiles[IDX_W'(tile_ptr)];
    wr_tile  = C_tile;
    if (tile_acc) begin
      for (int e = 0; e < N_ELEM; e++) begin
        wr_tile[e*DW_DATA +: DW_DATA] = cur_tile[e*DW_DATA +: DW_DATA] + C_tile[e*DW_DATA +: DW_DATA];
      end
    end
  end

  // Current output row: one tile row from each tile column, lowest tile column in the LSBs
  always_comb begin
    rd_base  = (32'(row) / TILE_M) * iterN;
    rd_sub   = 32'(row) % TILE_M;
    out_data = '0;
    for (int tn = 0; tn < iterN; tn++) begin
      out_data[tn*ROW_W +: ROW_W] = tiles[IDX_W'(rd_base + 32'(tn))][rd_sub*ROW_W +: ROW_W];
    end
  end

  // Control FSM, tile storage and registered stream/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int t = 0; t < N_iter; t++) tiles[t] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (tile_we && ptr_ok) tiles[IDX_W'(tile_ptr)] <= wr_tile;
          if (drain_start) begin
            state     <= DRAIN;
            row       <= '0;
            out_valid <= 1'b1;
            out_last  <= (M == 1);
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (row == DW_IDX'(M - 1)) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              row      <= row + DW_IDX'(1);
              out_last <= (row + DW_IDX'(1)) == DW_IDX'(M - 1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          row   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          for (int t = 0; t < N_iter; t++) tiles[t] <= '0;
        end
        default: begin
          state     <= IDLE;
          row       <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_cbuffer.sv
// Self-checking bench for tc_cbuffer: matrix-level reference model, randomized
// tiles and back-pressure, plus directed scenarios.
module tb_tc_cbuffer;

  localparam int M = 16, N = 16, TILE_M = 4, TILE_N = 4;
  localparam int iterN = N / TILE_N, N_iter = (M / TILE_M) * iterN;
  localparam int DW_MEM = 512, DW_IDX = 4, DW_DATA = 32;
  localparam int DW_TILE = TILE_M * TILE_N * DW_DATA;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               tile_we = 1'b0;
  logic               tile_acc = 1'b0;
  logic [DW_IDX-1:0]  tile_ptr = '0;
  logic [DW_TILE-1:0] C_tile = '0;
  logic               drain_start = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [DW_MEM-1:0]  out_data;
  logic [DW_IDX-1:0]  out_row;
  logic               out_last;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW_DATA-1:0] mdl [M][N];
  logic [DW_MEM-1:0]  got_rows [M];

  tc_cbuffer dut (
    .clk(clk), .reset(reset), .tile_we(tile_we), .tile_acc(tile_acc),
    .tile_ptr(tile_ptr), .C_tile(C_tile), .drain_start(drain_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) mdl[r][c] = '0;
  endfunction

  function automatic void model_write(input int ptr, input bit acc, input logic [DW_TILE-1:0] d);
    logic [DW_DATA-1:0] v;
    if (ptr >= N_iter) return;
    for (int i = 0; i < TILE_M; i++) begin
      for (int j = 0; j < TILE_N; j++) begin
        v = d[(i*TILE_N+j)*DW_DATA +: DW_DATA];
        if (acc) mdl[(ptr/iterN)*TILE_M+i][(ptr%iterN)*TILE_N+j] += v;
        else     mdl[(ptr/iterN)*TILE_M+i][(ptr%iterN)*TILE_N+j] = v;
      end
    end
  endfunction

  function automatic logic [DW_MEM-1:0] model_row(input int r);
    logic [DW_MEM-1:0] v = '0;
    for (int c = 0; c < N; c++) v[c*DW_DATA +: DW_DATA] = mdl[r][c];
    return v;
  endfunction

  function automatic logic [DW_TILE-1:0] rand_tile();
    logic [DW_TILE-1:0] v;
    for (int k = 0; k < DW_TILE/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic write_tile(input int ptr, input bit acc, input logic [DW_TILE-1:0] d);
    @(negedge clk);
    tile_we = 1'b1; tile_acc = acc; tile_ptr = DW_IDX'(ptr); C_tile = d;
    @(negedge clk);
    tile_we = 1'b0;
    model_write(ptr, acc, d);
  endtask

  // Starts a drain and follows it to IDLE, checking every row against the model.
  task automatic drain(input int mode, input bit noise, input bit co_write,
                       input int cw_ptr, input logic [DW_TILE-1:0] cw_data, output int cycles);
    int exp_row = 0;
    int cyc;
    bit r;
    bit stalled = 1'b0;
    logic [DW_MEM-1:0] hold_d = '0;
    logic [DW_IDX-1:0] hold_r = '0;
    @(negedge clk);
    drain_start = 1'b1;
    if (co_write) begin
      tile_we = 1'b1; tile_acc = 1'b0; tile_ptr = DW_IDX'(cw_ptr); C_tile = cw_data;
      model_write(cw_ptr, 1'b0, cw_data);
    end
    @(negedge clk);
    drain_start = 1'b0; tile_we = 1'b0;
    cyc = 1;
    while (exp_row < M && cyc < 300) begin
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL drain_status: valid=%b busy=%b done=%b expected 1 1 0 row %0d", out_valid, busy, done, exp_row);
      end
      n_checks++;
      if (out_row !== DW_IDX'(exp_row)) begin
        n_fail++; $display("FAIL out_row: got %0d expected %0d", out_row, exp_row);
      end
      n_checks++;
      if (out_data !== model_row(exp_row)) begin
        n_fail++; $display("FAIL out_data row %0d: got %0h expected %0h", exp_row, out_data, model_row(exp_row));
      end
      n_checks++;
      if (out_last !== (exp_row == M-1)) begin
        n_fail++; $display("FAIL out_last row %0d: got %b expected %b", exp_row, out_last, exp_row == M-1);
      end
      if (stalled) begin
        n_checks++;
        if (out_data !== hold_d || out_row !== hold_r) begin
          n_fail++; $display("FAIL stall_hold: row got %0d expected %0d", out_row, hold_r);
        end
      end
      case (mode)
        0: r = 1'b1;
        1: r = (((cyc-1) % 4) == 0) || (((cyc-1) % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        tile_we = 1'($urandom); tile_acc = 1'($urandom);
        tile_ptr = DW_IDX'($urandom); C_tile = rand_tile();
        drain_start = 1'($urandom);
      end
      out_ready = r;
      hold_d = out_data; hold_r = out_row; stalled = !r;
      @(negedge clk);
      cyc++;
      if (r) begin
        got_rows[exp_row] = hold_d;
        exp_row++;
      end
    end
    tile_we = 1'b0; drain_start = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (exp_row != M) begin
      n_fail++; $display("FAIL drain_timeout: accepted %0d rows expected %0d", exp_row, M);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL done_cycle: done=%b busy=%b valid=%b last=%b expected 1 1 0 0", done, busy, out_valid, out_last);
    end
    @(negedge clk);
    cyc++;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL back_to_idle: done=%b busy=%b valid=%b expected 0 0 0", done, busy, out_valid);
    end
    cycles = cyc;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_row !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: valid=%b last=%b row=%0d busy=%b done=%b expected all 0",
                         out_valid, out_last, out_row, busy, done);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    logic [DW_TILE-1:0] d;
    logic [127:0] e0, e3;
    int cyc;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'(k + 1);
    write_tile(0, 1'b0, d);
    drain(0, 1'b0, 1'b0, 0, '0, cyc);
    e0 = {32'd4, 32'd3, 32'd2, 32'd1};
    e3 = {32'd16, 32'd15, 32'd14, 32'd13};
    n_checks++;
    if (got_rows[0][127:0] !== e0 || got_rows[3][127:0] !== e3 || got_rows[0][511:128] !== '0) begin
      n_fail++; $display("FAIL basic_rows: row0 %0h row3 %0h expected %0h %0h", got_rows[0], got_rows[3], e0, e3);
    end
    n_checks++;
    if (cyc != M + 2) begin
      n_fail++; $display("FAIL drain_length: got %0d cycles expected %0d", cyc, M + 2);
    end
  endtask

  task automatic test_accumulate();
    logic [127:0] ones = {4{32'h1}};
    int cyc;
    write_tile(5, 1'b0, {16{32'hFFFF_FFFF}});
    write_tile(5, 1'b1, {16{32'h2}});
    drain(0, 1'b0, 1'b0, 0, '0, cyc);
    for (int r = 4; r < 8; r++) begin
      n_checks++;
      if (got_rows[r][255:128] !== ones || got_rows[r][127:0] !== '0 || got_rows[r][511:256] !== '0) begin
        n_fail++; $display("FAIL acc_lanes row %0d: got %0h expected lanes 4..7 = 1", r, got_rows[r]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int p = 0; p < N_iter; p++) write_tile(p, 1'b0, rand_tile());
    drain(1, 1'b0, 1'b0, 0, '0, cyc);
  endtask

  task automatic test_busy_ignores();
    int cyc;
    for (int k = 0; k < 10; k++) write_tile($urandom_range(0, N_iter-1), 1'($urandom), rand_tile());
    drain(2, 1'b1, 1'b0, 0, '0, cyc);
    drain(0, 1'b0, 1'b0, 0, '0, cyc);
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    for (int p = 0; p < N_iter; p++) write_tile(p, 1'b0, rand_tile());
    @(negedge clk);
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (out_row !== DW_IDX'(5) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_abort: row=%0d valid=%b expected 5 1", out_row, out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_row !== '0) begin
      n_fail++; $display("FAIL abort_state: valid=%b busy=%b done=%b row=%0d expected 0 0 0 0", out_valid, busy, done, out_row);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet: done=%b valid=%b expected 0 0", done, out_valid);
      end
    end
    model_clear();
    drain(0, 1'b0, 1'b0, 0, '0, cyc);
  endtask

  task automatic test_write_with_start();
    int cyc;
    drain(0, 1'b0, 1'b1, 15, {16{32'd7}}, cyc);
    n_checks++;
    if (got_rows[12][511:480] !== 32'd7) begin
      n_fail++; $display("FAIL same_cycle_write: got %0h expected 7", got_rows[12][511:480]);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_accumulate();
    test_backpressure();
    test_busy_ignores();
    test_reset_mid_drain();
    test_write_with_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
